// File: rtl/gesture_pkg.sv
// Shared types, defaults and the width-to-code quantiser for the gesture PWM encoder.
package gesture_pkg;

  typedef logic [7:0] gesture_t;

  localparam gesture_t GESTURE_NONE = 8'd0;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} enc_state_t;

  localparam int unsigned DEF_MIN_US    = 1000;
  localparam int unsigned DEF_STEP_US   = 100;
  localparam int unsigned DEF_NUM_CODES = 11;

  // Lowest width (us) that still rounds to code 1.
  function automatic int unsigned win_lo_us(input int unsigned min_us, input int unsigned step_us);
    return min_us - step_us / 2;
  endfunction

  // First width (us) past the top code; widths at or above this are rejected.
  function automatic int unsigned win_hi_us(input int unsigned min_us, input int unsigned step_us,
                                            input int unsigned num_codes);
    return min_us + (num_codes - 1) * step_us + step_us / 2;
  endfunction

  localparam int unsigned WIN_LO_US = win_lo_us(DEF_MIN_US, DEF_STEP_US);
  localparam int unsigned WIN_HI_US = win_hi_us(DEF_MIN_US, DEF_STEP_US, DEF_NUM_CODES);

  // Comparator chain: the highest code whose lower edge the width reaches wins.
  // Returns GESTURE_NONE outside [lo_us, hi_us).
  function automatic gesture_t quantise(input logic [15:0] width, input int unsigned lo_us,
                                        input int unsigned hi_us, input int unsigned step_us,
                                        input int unsigned num_codes);
    gesture_t    code;
    int unsigned w;
    w    = 32'(width);
    code = GESTURE_NONE;
    for (int unsigned i = 1; i <= num_codes; i++) begin
      if (w >= lo_us + (i - 1) * step_us) code = gesture_t'(i);
    end
    if (w >= hi_us) code = GESTURE_NONE;
    return code;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser plus edge detector for a slow asynchronous pin.
module pwm_edge_sync #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta, sync_q, prev_q;

  // Synchroniser chain and a history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
      prev_q <= RESET_LEVEL;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/gesture_pwm_encoder.sv
// Measures servo-style PWM high time and publishes a debounced 8-bit gesture code.
module gesture_pwm_encoder
  import gesture_pkg::*;
#(
  parameter int unsigned CLKS_PER_US  = 50,
  parameter int unsigned MIN_US       = DEF_MIN_US,
  parameter int unsigned STEP_US      = DEF_STEP_US,
  parameter int unsigned NUM_CODES    = DEF_NUM_CODES,
  parameter int unsigned MAX_PULSE_US = 2500,
  parameter int unsigned STABLE_COUNT = 3,
  parameter int unsigned TIMEOUT_US   = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output gesture_t    gesture,
  output logic        gesture_valid,
  output logic [15:0] width_us,
  output logic        pulse_error,
  output logic        signal_lost
);

  localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int unsigned GW = $clog2(TIMEOUT_US + 1);
  localparam int unsigned SW = $clog2(STABLE_COUNT + 1);
  localparam logic [PW-1:0] PRESC_TOP  = PW'(CLKS_PER_US - 1);
  localparam logic [GW-1:0] GAP_TOP    = GW'(TIMEOUT_US);
  localparam logic [GW-1:0] GAP_LAST   = GW'(TIMEOUT_US - 1);
  localparam logic [15:0]   MAX_WIDTH  = 16'(MAX_PULSE_US);
  localparam logic [SW-1:0] STABLE_TOP = SW'(STABLE_COUNT);
  localparam int unsigned   WIN_LO     = win_lo_us(MIN_US, STEP_US);
  localparam int unsigned   WIN_HI     = win_hi_us(MIN_US, STEP_US, NUM_CODES);

  enc_state_t    state_q, state_d;
  logic          sync_level, rise, fall;
  logic [PW-1:0] presc;
  logic          us_tick;
  logic [15:0]   width_cnt;
  logic [GW-1:0] gap_cnt;
  logic          gap_expire;
  logic          eval_go, eval_q, abort, timeout;
  gesture_t      code, cand_q, cand_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          lock;

  // Sync flops reset high: a pulse already in flight when reset releases shows
  // no rise, so it is discarded; the resulting fall is ignored in IDLE.
  pwm_edge_sync #(.RESET_LEVEL(1'b1)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pwm_in),
    .sync_out (sync_level),
    .rise     (rise),
    .fall     (fall)
  );

  assign us_tick    = (presc == PRESC_TOP);
  assign gap_expire = us_tick && (gap_cnt == GAP_LAST);
  assign code       = quantise(width_cnt, WIN_LO, WIN_HI, STEP_US, NUM_CODES);

  // Microsecond prescaler, realigned to every rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               presc <= '0;
    else if (rise || us_tick) presc <= '0;
    else                      presc <= presc + 1'b1;
  end

  // High-time counter in us, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    width_cnt <= '0;
    else if (rise) width_cnt <= '0;
    else if (state_q == HIGH && us_tick && width_cnt != '1) width_cnt <= width_cnt + 1'b1;
  end

  // Gap counter in us since the last rise; parks at the timeout value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    gap_cnt <= '0;
    else if (rise) gap_cnt <= '0;
    else if (state_q != HIGH && us_tick && gap_cnt != GAP_TOP) gap_cnt <= gap_cnt + 1'b1;
  end

  // FSM state register and the one-cycle-delayed evaluate request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      eval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      eval_q  <= eval_go;
    end
  end

  // Next state; a rise beats a timeout expiring in the same cycle.
  always_comb begin
    state_d = state_q;
    eval_go = 1'b0;
    abort   = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE, LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (gap_expire) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (fall) begin
          eval_go = 1'b1;
          state_d = LOW;
        end else if (sync_level && width_cnt > MAX_WIDTH) begin
          abort   = 1'b1;
          state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Candidate code and its run length.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (abort || timeout) begin
      cnt_d = '0;
    end else if (eval_q) begin
      if (code == GESTURE_NONE) begin
        cnt_d = '0;
      end else if (code == cand_q) begin
        cnt_d = (cnt_q == STABLE_TOP) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cand_d = code;
        cnt_d  = SW'(1);
      end
    end
    lock = eval_q && (cnt_d == STABLE_TOP) && (cand_d != gesture);
  end

  // Stability tracker registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q <= GESTURE_NONE;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // Published outputs and strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gesture       <= GESTURE_NONE;
      gesture_valid <= 1'b0;
      width_us      <= '0;
      pulse_error   <= 1'b0;
      signal_lost   <= 1'b0;
    end else begin
      gesture_valid <= 1'b0;
      pulse_error   <= abort || (eval_q && code == GESTURE_NONE);
      if (eval_q) width_us <= width_cnt;
      if (timeout) begin
        signal_lost   <= 1'b1;
        gesture       <= GESTURE_NONE;
        gesture_valid <= (gesture != GESTURE_NONE);
      end else if (rise) begin
        signal_lost <= 1'b0;
      end
      if (lock) begin
        gesture       <= cand_d;
        gesture_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gesture_pwm_encoder.sv
// Directed bench for gesture_pwm_encoder, run at 1 clk per us with a shortened timeout.
module tb_gesture_pwm_encoder;
  import gesture_pkg::*;

  localparam int unsigned TIMEOUT = 5000;
  localparam int unsigned GAP     = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pwm_in = 1'b0;
  gesture_t    gesture;
  logic        gesture_valid;
  logic [15:0] width_us;
  logic        pulse_error;
  logic        signal_lost;

  gesture_pwm_encoder #(
    .CLKS_PER_US (1),
    .TIMEOUT_US  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .gesture       (gesture),
    .gesture_valid (gesture_valid),
    .width_us      (width_us),
    .pulse_error   (pulse_error),
    .signal_lost   (signal_lost)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned n_valid = 0;
  int unsigned n_err = 0;

  // Strobe counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (gesture_valid) n_valid++;
    if (pulse_error)   n_err++;
  end

  typedef struct {
    int unsigned w;     // pulse high time, us
    int unsigned g;     // gesture after the pulse
    int unsigned wid;   // width_us after the pulse
    int unsigned err;   // pulse_error strobes during the pulse
    int unsigned val;   // gesture_valid strobes during the pulse
  } vec_t;

  vec_t vt[$];

  function automatic void add(input int unsigned w, input int unsigned g, input int unsigned wid,
                              input int unsigned err, input int unsigned val);
    vec_t v;
    v.w = w; v.g = g; v.wid = wid; v.err = err; v.val = val;
    vt.push_back(v);
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int unsigned w);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (w) @(negedge clk);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic run_vec(input int unsigned i);
    vec_t        v;
    int unsigned v0, e0;
    v  = vt[i];
    v0 = n_valid;
    e0 = n_err;
    pulse(v.w);
    #1;
    check($sformatf("v%0d(%0dus) gesture", i, v.w), gesture, v.g);
    check($sformatf("v%0d(%0dus) width_us", i, v.w), width_us, v.wid);
    check($sformatf("v%0d(%0dus) pulse_error", i, v.w), n_err - e0, v.err);
    check($sformatf("v%0d(%0dus) gesture_valid", i, v.w), n_valid - v0, v.val);
    check($sformatf("v%0d(%0dus) signal_lost", i, v.w), signal_lost, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " gesture"}, gesture, 0);
    check({tag, " gesture_valid"}, gesture_valid, 0);
    check({tag, " width_us"}, width_us, 0);
    check({tag, " pulse_error"}, pulse_error, 0);
    check({tag, " signal_lost"}, signal_lost, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned v0, e0, k;

    // 0-2: three 1500 us pulses lock code 6
    add(1500, 0, 1500, 0, 0); add(1500, 0, 1500, 0, 0); add(1500, 6, 1500, 0, 1);
    // 3-12: rounding boundaries and upper window edge
    add(WIN_LO_US + 99, 6, 1049, 0, 0); add(WIN_LO_US + 99, 6, 1049, 0, 0);
    add(WIN_LO_US + 99, 1, 1049, 0, 1);
    add(WIN_LO_US + 100, 1, 1050, 0, 0); add(WIN_LO_US + 100, 1, 1050, 0, 0);
    add(WIN_LO_US + 100, 2, 1050, 0, 1);
    add(WIN_HI_US - 1, 2, 2049, 0, 0); add(WIN_HI_US - 1, 2, 2049, 0, 0);
    add(WIN_HI_US - 1, 11, 2049, 0, 1);
    add(WIN_HI_US, 11, 2050, 1, 0);
    // 13-18: short pulse resets the run length
    add(1500, 11, 1500, 0, 0); add(1500, 11, 1500, 0, 0); add(900, 11, 900, 1, 0);
    add(1500, 11, 1500, 0, 0); add(1500, 11, 1500, 0, 0); add(1500, 6, 1500, 0, 1);
    // 19-24: aborted long pulse resets the run length, width_us holds
    add(1300, 6, 1300, 0, 0); add(1300, 6, 1300, 0, 0); add(3000, 6, 1300, 1, 0);
    add(1300, 6, 1300, 0, 0); add(1300, 6, 1300, 0, 0); add(1300, 4, 1300, 0, 1);
    // 25-34: alternating codes never settle
    for (int unsigned i = 0; i < 5; i++) begin
      add(1400, 4, 1400, 0, 0);
      add(1300, 4, 1300, 0, 0);
    end
    // 35-37: lock code 8
    add(1700, 4, 1700, 0, 0); add(1700, 4, 1700, 0, 0); add(1700, 8, 1700, 0, 1);
    // 38-40: recovery after signal loss
    add(1200, 0, 1200, 0, 0); add(1200, 0, 1200, 0, 0); add(1200, 3, 1200, 0, 1);
    // 41-43: after a mid-pulse reset
    add(1500, 0, 1500, 0, 0); add(1500, 0, 1500, 0, 0); add(1500, 6, 1500, 0, 1);

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int unsigned i = 0; i <= 37; i++) run_vec(i);

    // Signal loss: line held low past the timeout
    v0 = n_valid;
    e0 = n_err;
    repeat (TIMEOUT - 150) @(negedge clk);
    #1;
    check("before timeout signal_lost", signal_lost, 0);
    check("before timeout gesture", gesture, 8);
    k = 0;
    while (!signal_lost && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    #1;
    check("timeout signal_lost", signal_lost, 1);
    check("timeout gesture", gesture, 0);
    check("timeout gesture_valid", n_valid - v0, 1);
    check("timeout pulse_error", n_err - e0, 0);

    for (int unsigned i = 38; i <= 40; i++) run_vec(i);

    // Reset 500 us into a 1500 us pulse; the remainder must not be measured
    v0 = n_valid;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (500) @(negedge clk);
    reset = 1'b0;
    #1;
    check_zero("mid-pulse reset");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    e0 = n_err;
    repeat (995) @(negedge clk);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge clk);
    #1;
    check("discarded pulse width_us", width_us, 0);
    check("discarded pulse gesture", gesture, 0);
    check("discarded pulse pulse_error", n_err - e0, 0);
    check("discarded pulse gesture_valid", n_valid - v0, 0);

    for (int unsigned i = 41; i <= 43; i++) run_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
